// File: rtl/gecko_decode_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gecko_decode_scoreboard_pkg
// Description : Shared types and constants for the gecko decode scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package gecko_decode_scoreboard_pkg;

    // Architectural integer register count (x0..x31)
    localparam int GECKO_REG_COUNT = 32;

    // Issue sequencing state: normal issue or draining in-flight writes
    typedef enum logic [0:0] {
        GECKO_SCOREBOARD_RUN   = 1'b0,
        GECKO_SCOREBOARD_DRAIN = 1'b1
    } gecko_scoreboard_state_t;

endpackage
`default_nettype wire

// File: rtl/gecko_decode_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module      : gecko_scoreboard_counter
// Description : One per-register pending-write counter. Increments on issue,
//               decrements once per retiring writeback port, saturates at
//               zero and flags the cycle in which an underflow was attempted.
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_scoreboard_counter #(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     dec_a,
    input  logic                     dec_b,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     underflow
);

    logic [COUNTER_WIDTH-1:0]        r_count;
    logic signed [COUNTER_WIDTH+1:0] w_sum;
    logic                            w_unused_msb;

    // Two guard bits hold the full range count+1 .. count-2 without wrap
    always_comb begin
        w_sum = $signed({2'b00, r_count})
              + $signed({{(COUNTER_WIDTH+1){1'b0}}, inc})
              - $signed({{(COUNTER_WIDTH+1){1'b0}}, dec_a})
              - $signed({{(COUNTER_WIDTH+1){1'b0}}, dec_b});
    end

    // Overflow above MAX_PENDING is prevented upstream, so this bit carries no information
    assign w_unused_msb = w_sum[COUNTER_WIDTH];

    assign underflow = w_sum[COUNTER_WIDTH+1];
    assign count     = r_count;

    // Counter register, clamped to zero when a negative result is attempted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (underflow) begin
            r_count <= '0;
        end else begin
            r_count <= w_sum[COUNTER_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gecko_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : gecko_decode_scoreboard
// Description : Per-register pending-write scoreboard for gecko decode.
//               Tracks in-flight writes for x1..x31, answers operand
//               readability / destination writeability, gates issue, and
//               provides a drain sequence that blocks issue until every
//               in-flight write has retired.
//               Optional macro GECKO_SCOREBOARD_BYPASS_EN: lookups and
//               issue_ready also see same-cycle writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_decode_scoreboard
    import gecko_decode_scoreboard_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2,
    parameter int MAX_PENDING   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    output logic       issue_ready,
    input  logic       wb_exec_valid,
    input  logic [4:0] wb_exec_addr,
    input  logic       wb_mem_valid,
    input  logic [4:0] wb_mem_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    output logic       rs1_valid,
    output logic       rs2_valid,
    output logic       rd_writeable,
    input  logic       drain_req,
    output logic       drain_busy,
    output logic       drain_done,
    output logic       err_underflow
);

    localparam logic [COUNTER_WIDTH-1:0] c_max_pending = COUNTER_WIDTH'(MAX_PENDING);
    localparam logic [COUNTER_WIDTH-1:0] c_one         = COUNTER_WIDTH'(1);

    gecko_scoreboard_state_t r_state;
    gecko_scoreboard_state_t w_state_next;
    logic                    r_drain_done;
    logic                    r_err_underflow;

    logic [GECKO_REG_COUNT-1:0][COUNTER_WIDTH-1:0] w_count;
    logic [GECKO_REG_COUNT-1:0]                    w_underflow;

    logic                     w_fire;
    logic                     w_all_zero;
    logic                     w_issue_room;
    logic [COUNTER_WIDTH-1:0] w_rs1_cnt;
    logic [COUNTER_WIDTH-1:0] w_rs2_cnt;
    logic [COUNTER_WIDTH-1:0] w_rd_cnt;
    logic [COUNTER_WIDTH-1:0] w_issue_cnt;

    // x0 never holds a pending write
    assign w_count[0]     = '0;
    assign w_underflow[0] = 1'b0;

    assign w_fire = issue_valid && issue_ready;

    // One counter per writable register, each with its own address decode
    generate
        for (genvar g = 1; g < GECKO_REG_COUNT; g++) begin : g_reg
            gecko_scoreboard_counter #(
                .COUNTER_WIDTH (COUNTER_WIDTH)
            ) u_counter (
                .clk       (clk),
                .rst       (rst),
                .inc       (w_fire        && (issue_rd     == 5'(g))),
                .dec_a     (wb_exec_valid && (wb_exec_addr == 5'(g))),
                .dec_b     (wb_mem_valid  && (wb_mem_addr  == 5'(g))),
                .count     (w_count[g]),
                .underflow (w_underflow[g])
            );
        end
    endgenerate

    assign w_rs1_cnt   = w_count[rs1_addr];
    assign w_rs2_cnt   = w_count[rs2_addr];
    assign w_rd_cnt    = w_count[rd_addr];
    assign w_issue_cnt = w_count[issue_rd];
    assign w_all_zero  = ~|w_count;

`ifdef GECKO_SCOREBOARD_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_hit;
    logic w_issue_hit;

    assign w_rs1_hit   = (wb_exec_valid && (wb_exec_addr == rs1_addr)) ||
                         (wb_mem_valid  && (wb_mem_addr  == rs1_addr));
    assign w_rs2_hit   = (wb_exec_valid && (wb_exec_addr == rs2_addr)) ||
                         (wb_mem_valid  && (wb_mem_addr  == rs2_addr));
    assign w_rd_hit    = (wb_exec_valid && (wb_exec_addr == rd_addr)) ||
                         (wb_mem_valid  && (wb_mem_addr  == rd_addr));
    assign w_issue_hit = (wb_exec_valid && (wb_exec_addr == issue_rd)) ||
                         (wb_mem_valid  && (wb_mem_addr  == issue_rd));

    // Lookups treat a write retiring this cycle as already gone
    always_comb begin
        rs1_valid    = (w_rs1_cnt == '0) || ((w_rs1_cnt == c_one) && w_rs1_hit);
        rs2_valid    = (w_rs2_cnt == '0) || ((w_rs2_cnt == c_one) && w_rs2_hit);
        rd_writeable = (w_rd_cnt < c_max_pending) ||
                       ((w_rd_cnt == c_max_pending) && w_rd_hit);
        w_issue_room = (w_issue_cnt < c_max_pending) ||
                       ((w_issue_cnt == c_max_pending) && w_issue_hit);
    end
`else
    // Lookups from registered counts only
    always_comb begin
        rs1_valid    = (w_rs1_cnt == '0);
        rs2_valid    = (w_rs2_cnt == '0);
        rd_writeable = (w_rd_cnt < c_max_pending);
        w_issue_room = (w_issue_cnt < c_max_pending);
    end
`endif

    assign issue_ready   = (r_state == GECKO_SCOREBOARD_RUN) && !drain_req && w_issue_room;
    assign drain_busy    = (r_state == GECKO_SCOREBOARD_DRAIN);
    assign drain_done    = r_drain_done;
    assign err_underflow = r_err_underflow;

    // Drain sequencing: enter on request, leave once every counter reads zero
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GECKO_SCOREBOARD_RUN: begin
                if (drain_req) begin
                    w_state_next = GECKO_SCOREBOARD_DRAIN;
                end
            end
            GECKO_SCOREBOARD_DRAIN: begin
                if (w_all_zero) begin
                    w_state_next = GECKO_SCOREBOARD_RUN;
                end
            end
            default: w_state_next = GECKO_SCOREBOARD_RUN;
        endcase
    end

    // State register, drain completion pulse and sticky underflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= GECKO_SCOREBOARD_RUN;
            r_drain_done    <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_drain_done    <= (r_state == GECKO_SCOREBOARD_DRAIN) && w_all_zero;
            r_err_underflow <= r_err_underflow || (|w_underflow);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gecko_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_gecko_decode_scoreboard
// Description : Directed self-checking bench for gecko_decode_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gecko_decode_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       wb_exec_valid;
    logic [4:0] wb_exec_addr;
    logic       wb_mem_valid;
    logic [4:0] wb_mem_addr;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       rs1_valid;
    logic       rs2_valid;
    logic       rd_writeable;
    logic       drain_req;
    logic       drain_busy;
    logic       drain_done;
    logic       err_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gecko_decode_scoreboard #(
        .COUNTER_WIDTH (2),
        .MAX_PENDING   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .wb_exec_valid (wb_exec_valid),
        .wb_exec_addr  (wb_exec_addr),
        .wb_mem_valid  (wb_mem_valid),
        .wb_mem_addr   (wb_mem_addr),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .rs1_valid     (rs1_valid),
        .rs2_valid     (rs2_valid),
        .rd_writeable  (rd_writeable),
        .drain_req     (drain_req),
        .drain_busy    (drain_busy),
        .drain_done    (drain_done),
        .err_underflow (err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        wb_exec_valid = 1'b0;
        wb_mem_valid  = 1'b0;
        drain_req     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        issue_rd = 5'd0; wb_exec_addr = 5'd0; wb_mem_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;

        // ---- reset values
        #12;
        check("rst_rs1_valid",   32'(rs1_valid),     32'd1);
        check("rst_rd_writeable",32'(rd_writeable),  32'd1);
        check("rst_issue_ready", 32'(issue_ready),   32'd1);
        check("rst_drain_busy",  32'(drain_busy),    32'd0);
        check("rst_drain_done",  32'(drain_done),    32'd0);
        check("rst_err",         32'(err_underflow), 32'd0);
        tick();
        rst = 1'b0;

        // ---- fill x5 to MAX_PENDING
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick(); tick(); tick();
        issue_valid = 1'b0; rd_addr = 5'd5; rs1_addr = 5'd5;
        #1;
        check("x5_full_writeable", 32'(rd_writeable), 32'd0);
        check("x5_full_ready",     32'(issue_ready),  32'd0);
        check("x5_full_rs1",       32'(rs1_valid),    32'd0);
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd5;
        #1;
`ifdef GECKO_SCOREBOARD_BYPASS_EN
        check("x5_wb_same_ready",  32'(issue_ready),  32'd1);
`else
        check("x5_wb_same_ready",  32'(issue_ready),  32'd0);
`endif
        tick();
        check("x5_wb_next_ready",  32'(issue_ready),  32'd1);
        check("x5_wb_next_wr",     32'(rd_writeable), 32'd1);
        tick(); tick();
        wb_exec_valid = 1'b0;
        #1;
        check("x5_empty_rs1",      32'(rs1_valid),    32'd1);

        // ---- issue and writeback same register same cycle
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        wb_mem_valid = 1'b1; wb_mem_addr = 5'd7;
        tick();
        idle(); rs1_addr = 5'd7; rd_addr = 5'd7;
        #1;
        check("x7_net0_rs1",       32'(rs1_valid),    32'd0);
        check("x7_net0_writeable", 32'(rd_writeable), 32'd1);
        wb_mem_valid = 1'b1;
        tick();
        idle();
        #1;
        check("x7_retired_rs1",    32'(rs1_valid),    32'd1);

        // ---- double writeback on one register
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick(); tick();
        idle();
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd9;
        wb_mem_valid  = 1'b1; wb_mem_addr  = 5'd9;
        tick();
        idle(); rs2_addr = 5'd9;
        #1;
        check("x9_dec2_rs2",       32'(rs2_valid),     32'd1);
        check("x9_dec2_err",       32'(err_underflow), 32'd0);

        // ---- x0 is never tracked
        issue_valid = 1'b1; issue_rd = 5'd0;
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd0;
        wb_mem_valid  = 1'b1; wb_mem_addr  = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
        for (int i = 0; i < 10; i++) tick();
        check("x0_issue_ready",    32'(issue_ready),   32'd1);
        idle();
        #1;
        check("x0_rs1",            32'(rs1_valid),     32'd1);
        check("x0_rs2",            32'(rs2_valid),     32'd1);
        check("x0_writeable",      32'(rd_writeable),  32'd1);
        check("x0_err",            32'(err_underflow), 32'd0);

        // ---- underflow on empty x9
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd9; rs2_addr = 5'd9;
        tick();
        idle();
        #1;
        check("x9_uf_err",         32'(err_underflow), 32'd1);
        check("x9_uf_rs2",         32'(rs2_valid),     32'd1);
        tick();
        check("x9_uf_sticky",      32'(err_underflow), 32'd1);

        // ---- drain with x3=1, x4=2
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick(); tick();
        idle(); issue_rd = 5'd3;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        #1;
        check("drain_busy",        32'(drain_busy),  32'd1);
        check("drain_ready",       32'(issue_ready), 32'd0);
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd3;
        tick(); idle();
        tick();
        wb_mem_valid = 1'b1; wb_mem_addr = 5'd4;
        tick(); idle();
        tick();
        check("drain_mid_busy",    32'(drain_busy),  32'd1);
        check("drain_mid_done",    32'(drain_done),  32'd0);
        wb_exec_valid = 1'b1; wb_exec_addr = 5'd4;
        tick(); idle();
        #1;
        check("drain_zero_busy",   32'(drain_busy),  32'd1);
        check("drain_zero_done",   32'(drain_done),  32'd0);
        tick();
        check("drain_exit_done",   32'(drain_done),  32'd1);
        check("drain_exit_busy",   32'(drain_busy),  32'd0);
        check("drain_exit_ready",  32'(issue_ready), 32'd1);
        tick();
        check("drain_done_pulse",  32'(drain_done),  32'd0);

        // ---- drain with nothing in flight still spends one cycle
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        #1;
        check("empty_drain_busy",  32'(drain_busy),  32'd1);
        check("empty_drain_done0", 32'(drain_done),  32'd0);
        tick();
        check("empty_drain_done",  32'(drain_done),  32'd1);
        check("empty_drain_run",   32'(drain_busy),  32'd0);

        // ---- async reset in the middle of a drain
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        idle(); rs1_addr = 5'd3;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        #1;
        check("mid_busy_pre",      32'(drain_busy),    32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",      32'(drain_busy),    32'd0);
        check("mid_rst_ready",     32'(issue_ready),   32'd1);
        check("mid_rst_rs1",       32'(rs1_valid),     32'd1);
        check("mid_rst_err",       32'(err_underflow), 32'd0);
        check("mid_rst_done",      32'(drain_done),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done",     32'(drain_done),    32'd0);
        check("post_rst_busy",     32'(drain_busy),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gecko_decode_scoreboard.md
Name: gecko_decode_scoreboard

Overview:
- Per-register pending-write scoreboard that sequences instruction issue out of gecko decode.
- Decode presents rd on issue; the execute and memory/system writeback paths retire writes.
- Provides operand readability and destination writeability for rs1/rs2/rd.
- Drain state machine blocks issue until all in-flight writes retire; used before system ops and after redirects.

Parameters:
- COUNTER_WIDTH, 2, width of each per-register pending-write counter.
- MAX_PENDING, 3, count at which a register is full; must be <= 2**COUNTER_WIDTH-1 and >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  decode issuing an instruction that writes rd
- issue_rd  in  5  destination register of issuing instruction
- issue_ready  out  1  scoreboard accepts issue this cycle
- wb_exec_valid  in  1  execute writeback retiring one write
- wb_exec_addr  in  5  execute writeback register
- wb_mem_valid  in  1  memory/system writeback retiring one write
- wb_mem_addr  in  5  memory/system writeback register
- rs1_addr  in  5  lookup address
- rs2_addr  in  5  lookup address
- rd_addr  in  5  lookup address
- rs1_valid  out  1  no pending write to rs1
- rs2_valid  out  1  no pending write to rs2
- rd_writeable  out  1  rd count < MAX_PENDING
- drain_req  in  1  request drain
- drain_busy  out  1  FSM in DRAIN
- drain_done  out  1  one-cycle pulse on DRAIN->RUN
- err_underflow  out  1  sticky: writeback hit a zero counter

Behaviour:
- Reset (async, rst=1): all 32 counters 0, FSM=RUN, drain_busy=0, drain_done=0, err_underflow=0. rs1_valid/rs2_valid/rd_writeable then read 1; issue_ready=1 unless drain_req=1.
- x0: counter hardwired 0. Issue or writeback to x0 changes nothing and never sets err_underflow. Lookups of x0 always report valid/writeable.
- Lookups are combinational from registered counters:
  - rsN_valid = (count[rsN_addr]==0).
  - rd_writeable = (count[rd_addr] < MAX_PENDING).
- issue_ready = (state==RUN) && !drain_req && (count[issue_rd] < MAX_PENDING). It must not depend on issue_valid.
- Issue fires when issue_valid && issue_ready.
- Counter update per register each cycle: next = count + inc - dec_exec - dec_mem.
  - inc = fire && issue_rd==r.
  - Each dec is that port's valid && addr==r.
  - Compute in COUNTER_WIDTH+2 signed arithmetic.
- Boundary cases:
  - Simultaneous issue and one writeback on the same register: net 0.
  - Both writebacks on the same register: decrement by 2.
  - Any result < 0: saturate to 0 and set err_underflow (sticky until reset).
  - Result > MAX_PENDING cannot occur, because issue_ready gates inc.
- FSM:
  - RUN: drain_req=1 -> DRAIN next cycle.
  - DRAIN: issue_ready=0, drain_busy=1; drain_req ignored. When all counters are 0 (registered value) -> RUN, and drain_done=1 for that one transition cycle.
  - drain_req asserted when all counters are already 0: still spends one cycle in DRAIN, then drain_done.
  - Reset mid-drain: RUN, no drain_done.
- drain_done is registered: asserted in the first RUN cycle after DRAIN.

Optional Feature:
- Macro: GECKO_SCOREBOARD_BYPASS_EN.
- Defined: rs1_valid/rs2_valid also assert when the registered count is 1 and a same-cycle writeback (either port) targets that address. rd_writeable also asserts when count==MAX_PENDING and a same-cycle writeback targets rd_addr. issue_ready uses the same bypassed fullness. This adds a combinational path wb -> ready.
- Undefined: all lookups and issue_ready use registered counts only; one cycle later than bypass.
- Counter update arithmetic is identical in both builds.

Decomposition:
- Package gecko (shared): gecko_scoreboard_state_t enum {GECKO_SCOREBOARD_RUN, GECKO_SCOREBOARD_DRAIN}; localparam GECKO_REG_COUNT=32.
- Sub-module gecko_scoreboard_counter: one saturating up/down counter with inc, dec_a, dec_b, underflow flag. Instantiated 31 times via generate (x0 excluded).
- Top holds FSM, address decoders, lookup muxes and all-zero reduction.

Test Plan:
- Reset then issue rd=5 three times (MAX_PENDING=3) -> rd_writeable(rd=5)=0 and issue_ready=0 for issue_rd=5. One wb_exec addr=5 -> issue_ready=1 next cycle (same cycle with BYPASS_EN).
- Issue rd=7 with wb_mem addr=7 same cycle, count=1 beforehand -> count stays 1; rs1_valid(rs1=7)=0.
- Count[9]=2, wb_exec and wb_mem both addr=9 -> rs2_valid(rs2=9)=1 next cycle; err_underflow=0. Repeat one wb to 9 -> err_underflow=1, count stays 0.
- Issue rd=0 ×10, wb addr=0 -> all outputs for x0 stay valid/writeable; err_underflow=0.
- Counts x3=1, x4=2; drain_req pulse -> drain_busy=1, issue_ready=0. Retire three writes over 5 cycles -> drain_done=1 one cycle after last counter hits 0, then issue_ready=1.
- rst asserted mid-DRAIN asynchronously (between clock edges) -> outputs return to reset values immediately; no drain_done pulse.
